// File: rtl/prog_loader_if.sv
// Byte-stream valid/ready channel feeding the program loader.
// The host drives the master side; the loader is the slave.
interface prog_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes im/dm bytes and holds the CPU in reset until GO.
// Frame: CMD, ADDR_HI, ADDR_LO, LEN, LEN payload bytes, CSUM (sum of payload mod 256).
module prog_loader #(
    parameter int unsigned ADDR_WIDTH = 8  // 1..16
) (
    input  logic                  clk,
    input  logic                  reset,
    prog_loader_if.slave          in_if,
    output logic                  im_we,
    output logic                  dm_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  err_cmd,
    output logic                  err_csum
);

    typedef enum logic [2:0] {
        StIdle, StAhi, StAlo, StLen, StData, StCsum, StRun
    } state_e;

    localparam logic [7:0] CmdIm = 8'hA5;
    localparam logic [7:0] CmdDm = 8'h5A;
    localparam logic [7:0] CmdGo = 8'hFF;

    state_e                state_q, state_d;
    logic                  tgt_dm_q, tgt_dm_d;
    logic [7:0]            addr_hi_q, addr_hi_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            sum_q, sum_d;
    logic                  im_we_q, im_we_d;
    logic                  dm_we_q, dm_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]            mem_wdata_q, mem_wdata_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  busy_q, busy_d;
    logic                  err_cmd_q, err_cmd_d;
    logic                  err_csum_q, err_csum_d;

    logic        hs;
    logic [15:0] start_addr;
    logic        unused_start_addr;

    assign in_if.in_ready = (state_q != StRun);
    assign hs             = in_if.in_valid & in_if.in_ready;
    assign start_addr     = {addr_hi_q, in_if.in_data};
    // Address bits above ADDR_WIDTH are deliberately discarded.
    assign unused_start_addr = ^start_addr;

    always_comb begin
        state_d     = state_q;
        tgt_dm_d    = tgt_dm_q;
        addr_hi_d   = addr_hi_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        sum_d       = sum_q;
        im_we_d     = 1'b0;
        dm_we_d     = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_cmd_d   = err_cmd_q;
        err_csum_d  = err_csum_q;

        if (hs) begin
            unique case (state_q)
                StIdle: begin
                    if (in_if.in_data == CmdIm || in_if.in_data == CmdDm) begin
                        tgt_dm_d = (in_if.in_data == CmdDm);
                        state_d  = StAhi;
                    end else if (in_if.in_data == CmdGo) begin
                        state_d = StRun;
                    end else begin
                        err_cmd_d = 1'b1;
                    end
                end
                StAhi: begin
                    addr_hi_d = in_if.in_data;
                    state_d   = StAlo;
                end
                StAlo: begin
                    addr_d  = start_addr[ADDR_WIDTH-1:0];
                    state_d = StLen;
                end
                StLen: begin
                    cnt_d   = in_if.in_data;
                    sum_d   = 8'h00;
                    state_d = (in_if.in_data != 8'h00) ? StData : StCsum;
                end
                StData: begin
                    im_we_d     = ~tgt_dm_q;
                    dm_we_d     = tgt_dm_q;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = in_if.in_data;
                    addr_d      = addr_q + ADDR_WIDTH'(1);
                    sum_d       = sum_q + in_if.in_data;
                    cnt_d       = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_d = StCsum;
                    end
                end
                StCsum: begin
                    if (in_if.in_data != sum_q) begin
                        err_csum_d = 1'b1;
                    end
                    state_d = StIdle;
                end
                default: state_d = state_q;
            endcase
        end

        busy_d     = (state_d != StIdle) && (state_d != StRun);
        cpu_hold_d = cpu_hold_q & (state_d != StRun);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            tgt_dm_q    <= 1'b0;
            addr_hi_q   <= 8'h00;
            addr_q      <= '0;
            cnt_q       <= 8'h00;
            sum_q       <= 8'h00;
            im_we_q     <= 1'b0;
            dm_we_q     <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'h00;
            cpu_hold_q  <= 1'b1;
            busy_q      <= 1'b0;
            err_cmd_q   <= 1'b0;
            err_csum_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_dm_q    <= tgt_dm_d;
            addr_hi_q   <= addr_hi_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            im_we_q     <= im_we_d;
            dm_we_q     <= dm_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            busy_q      <= busy_d;
            err_cmd_q   <= err_cmd_d;
            err_csum_q  <= err_csum_d;
        end
    end

    assign im_we     = im_we_q;
    assign dm_we     = dm_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign busy      = busy_q;
    assign err_cmd   = err_cmd_q;
    assign err_csum  = err_csum_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

Byte-stream program loader upstream of the `CPU` core. It accepts framed bytes over a valid/ready handshake and writes them into the instruction memory (`im`) or data memory (`dm`) byte arrays, using the same big-endian byte order the CPU fetches. It holds the CPU in reset until a GO command arrives, then releases it. This replaces hierarchical memory pokes from benches and lets a host or UART bridge boot the core.

## Interface
- `ADDR_WIDTH`, default 8: byte-address width of `im`/`dm`; addresses wrap modulo 2^ADDR_WIDTH.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: `in_data` is valid this cycle.
- `in_data`, input, 8: stream byte.
- `in_ready`, output, 1: loader accepts a byte; transfer occurs when `in_valid & in_ready`.
- `im_we`, output, 1: one-cycle write strobe to instruction memory.
- `dm_we`, output, 1: one-cycle write strobe to data memory.
- `mem_addr`, output, ADDR_WIDTH: byte address for the `im_we`/`dm_we` write.
- `mem_wdata`, output, 8: byte to write.
- `cpu_hold`, output, 1: active-high reset to the CPU; 1 until GO.
- `busy`, output, 1: a frame is in progress (state not IDLE or RUN).
- `err_cmd`, output, 1: sticky flag for an unknown command byte.
- `err_csum`, output, 1: sticky flag for a checksum mismatch.

## Operation
- Frame: CMD, ADDR_HI, ADDR_LO, LEN, LEN payload bytes, CSUM.
- CMD values:
  - 0xA5: write to `im`.
  - 0x5A: write to `dm`.
  - 0xFF: GO. GO is a single byte with no further fields.
- Start address is {ADDR_HI, ADDR_LO} truncated to ADDR_WIDTH. Each payload byte goes to the current address, then the address increments by 1 and wraps at 2^ADDR_WIDTH.
- LEN = 0 means no payload; the next byte is CSUM and must be 0x00.
- CSUM: 8-bit sum modulo 256 of the payload bytes only. A mismatch sets `err_csum`. Bytes already written stay written. The FSM returns to IDLE either way.
- FSM states and transitions:
  - IDLE: 0xA5 or 0x5A latches the target and goes to AHI. 0xFF goes to RUN. Any other byte sets `err_cmd` and stays in IDLE.
  - AHI → ALO → LEN.
  - LEN: goes to DATA if LEN ≠ 0, else to CSUM.
  - DATA: stays until the byte counter reaches 0, then goes to CSUM.
  - CSUM → IDLE.
  - RUN: terminal until `reset`.
- The FSM advances only on handshake cycles. A stall (`in_valid` = 0) holds all state.
- `in_ready` = (state ≠ RUN). It is never deasserted mid-frame.
- Error flags clear only on `reset`.
- Reset values: state IDLE; `in_ready` 1; `im_we` 0; `dm_we` 0; `mem_addr` 0; `mem_wdata` 0; `cpu_hold` 1; `busy` 0; `err_cmd` 0; `err_csum` 0.

## Timing
- Write path: a payload byte accepted at edge n drives `im_we` or `dm_we` = 1, with registered `mem_addr`/`mem_wdata`, during cycle n+1 (one cycle of latency). The strobe is exactly one cycle per byte.
- Back-to-back payload bytes give back-to-back strobes with consecutive addresses; no bubbles are inserted.
- `im_we` and `dm_we` are never high together. Strobes never fire outside DATA handshakes.
- `cpu_hold` falls in the cycle after the GO byte is accepted. The CPU therefore sees its first un-reset edge at n+2.
- `busy` is registered. It rises the cycle after CMD 0xA5/0x5A is accepted and falls the cycle after CSUM is accepted.
- Reset mid-frame: asynchronous return to reset values. A partial frame is abandoned; memory contents are untouched beyond writes that already completed.
- LEN bytes that cross the top of the address space wrap to 0 without error.

## Test plan
- Load `im`: frame A5 00 00 04 3C 01 10 01, CSUM 0x4E. Required: `im_we` pulses at addresses 0–3 with data 3C/01/10/01; no error flags; `busy` returns to 0.
- Load `dm` with stalls: frame 5A 00 1C 04 00 00 00 08, CSUM 08, with `in_valid` toggling every other cycle. Required: `dm_we` writes addresses 28–31 correctly, one strobe per accepted byte; `im_we` stays 0.
- Bad checksum: frame A5 00 10 02 AA 55, CSUM 00. Required: both bytes are written to addresses 16–17; `err_csum` = 1 and stays set; the next valid frame still loads.
- Unknown command and wrap: byte 0x33 sets `err_cmd`. Then frame A5 00 FF 02 11 22, CSUM 33. Required: writes land at 255 and then 0.
- GO: after loading the program, send 0xFF. Required: `cpu_hold` 1→0 one cycle later; `in_ready` = 0 thereafter; further `in_valid` is ignored.
- Reset mid-DATA: assert `reset` low after two of four payload bytes. Required: all outputs return immediately to reset values; only two writes occurred; a fresh frame after reset is accepted.
